// File: rtl/sdm_dec.sv
// sdm_dec: decimating accumulator summing 2^LOG2N signed 4-bit symbols into one valid/ready sample
module sdm_dec #(
    parameter int LOG2N = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   clear,
    input  logic                   full,
    input  logic [3:0]             rdata,
    output logic                   pop,
    output logic signed [LOG2N+3:0] dout,
    output logic                   dvalid,
    input  logic                   dready,
    output logic                   overrun,
    output logic [LOG2N-1:0]       cnt
);
    localparam int W = LOG2N + 4;
    typedef enum logic [1:0] {S_IDLE, S_POP, S_WAIT} state_t;
    state_t state;
    logic signed [W-1:0] acc, sym, sum;
    logic capture, last;
    assign sym     = {{LOG2N{rdata[3]}}, rdata};
    assign sum     = (cnt == '0 ? {W{1'b0}} : acc) + sym;
    assign capture = state == S_IDLE && en && full;
    assign last    = &cnt;
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            state   <= S_IDLE;
            pop     <= 1'b0;
            dout    <= '0;
            dvalid  <= 1'b0;
            overrun <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
        end else begin
            state <= capture ? S_POP : state == S_POP ? S_WAIT : state == S_WAIT && !full ? S_IDLE : state;
            pop   <= capture;
            if (dvalid && dready) dvalid <= 1'b0;
            if (capture) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
                if (last) begin
                    dout   <= sum;
                    dvalid <= 1'b1;
                    if (dvalid && !dready) overrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdm_dec.sv
// tb_sdm_dec: table, directed and randomized checks of sdm_dec with LOG2N=2
module tb_sdm_dec;
    logic clk = 1'b0;
    logic rstn, en, clear, full, dready;
    logic [3:0] rdata;
    logic pop, dvalid, overrun;
    logic signed [5:0] dout;
    logic [1:0] cnt;

    sdm_dec #(.LOG2N(2)) dut (
        .clk(clk), .rstn(rstn), .en(en), .clear(clear), .full(full), .rdata(rdata),
        .pop(pop), .dout(dout), .dvalid(dvalid), .dready(dready), .overrun(overrun), .cnt(cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int at_dout, at_dvalid, at_ovr, at_cnt;

    typedef struct {
        int s[4];
        int exp;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // one full episode: raise full, expect pop next cycle, drop full, record outputs seen with pop
    task automatic send(input int s, input bit d);
        @(negedge clk);
        full = 1'b1;
        rdata = 4'(s);
        dready = d;
        @(negedge clk);
        chk("pop", int'(pop), 1);
        at_dout = $signed(dout);
        at_dvalid = int'(dvalid);
        at_ovr = int'(overrun);
        at_cnt = int'(cnt);
        full = 1'b0;
        @(negedge clk);
        chk("pop_width", int'(pop), 0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int pops, k, acc, mdout, s;
        bit mv, mo, d;
        vecs[0] = '{'{-8, -8, -8, -8}, -32};
        vecs[1] = '{'{3, -1, -5, 2}, -1};
        vecs[2] = '{'{7, 7, 7, 7}, 28};
        vecs[3] = '{'{1, 2, 3, 4}, 10};
        vecs[4] = '{'{-8, 7, -8, 7}, -2};

        rstn = 1'b0; en = 1'b1; clear = 1'b0; full = 1'b1; rdata = 4'd7; dready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_pop", int'(pop), 0);
            chk("rst_dout", $signed(dout), 0);
            chk("rst_dvalid", int'(dvalid), 0);
            chk("rst_overrun", int'(overrun), 0);
            chk("rst_cnt", int'(cnt), 0);
        end
        full = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_cnt", int'(cnt), 0);

        // positive full scale
        for (int i = 0; i < 4; i++) send(7, 1'b1);
        chk("pos_dout", at_dout, 28);
        chk("pos_dvalid", at_dvalid, 1);
        chk("pos_dvalid_after", int'(dvalid), 0);

        // table of whole frames
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) send(vecs[v].s[i], 1'b1);
            chk("tbl_dout", at_dout, vecs[v].exp);
            chk("tbl_dvalid", at_dvalid, 1);
            chk("tbl_cnt", at_cnt, 0);
        end

        // held full: one capture only
        pulse_clear();
        @(negedge clk);
        full = 1'b1;
        rdata = 4'd3;
        pops = 0;
        repeat (10) begin
            @(negedge clk);
            pops += int'(pop);
        end
        full = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_pops", pops, 1);
        chk("held_cnt", int'(cnt), 1);

        // en=0 blocks captures
        pulse_clear();
        en = 1'b0;
        full = 1'b1;
        pops = 0;
        repeat (5) begin
            @(negedge clk);
            pops += int'(pop);
        end
        full = 1'b0;
        en = 1'b1;
        @(negedge clk);
        chk("en0_pops", pops, 0);
        chk("en0_cnt", int'(cnt), 0);

        // overrun
        for (int i = 0; i < 4; i++) send(1, 1'b0);
        chk("ovr_dout1", at_dout, 4);
        chk("ovr_flag1", at_ovr, 0);
        for (int i = 0; i < 4; i++) send(1, 1'b0);
        chk("ovr_dout2", at_dout, 4);
        chk("ovr_dvalid2", at_dvalid, 1);
        chk("ovr_flag2", at_ovr, 1);
        @(negedge clk);
        dready = 1'b1;
        @(negedge clk);
        dready = 1'b0;
        chk("ovr_consumed", int'(dvalid), 0);
        chk("ovr_sticky", int'(overrun), 1);
        pulse_clear();
        chk("ovr_cleared", int'(overrun), 0);

        // clear mid-frame
        send(5, 1'b1);
        send(5, 1'b1);
        chk("mid_cnt", at_cnt, 2);
        pulse_clear();
        chk("mid_cnt_clr", int'(cnt), 0);
        chk("mid_dout_clr", $signed(dout), 0);
        for (int i = 0; i < 4; i++) send(1, 1'b1);
        chk("mid_dout", at_dout, 4);

        // clear while pop is high drops the pop
        @(negedge clk);
        full = 1'b1;
        rdata = 4'd2;
        @(negedge clk);
        chk("popclr_pop", int'(pop), 1);
        clear = 1'b1;
        full = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        chk("popclr_pop0", int'(pop), 0);
        chk("popclr_cnt", int'(cnt), 0);

        // randomized frames against a transaction-level model
        pulse_clear();
        k = 0; acc = 0; mdout = 0; mv = 1'b0; mo = 1'b0;
        for (int n = 0; n < 200; n++) begin
            s = int'($urandom_range(0, 15)) - 8;
            d = 1'($urandom_range(0, 1));
            acc = (k == 0) ? s : acc + s;
            k = (k + 1) % 4;
            if (k == 0) begin
                if (mv && !d) mo = 1'b1;
                mdout = acc;
                mv = 1'b1;
            end else if (d) begin
                mv = 1'b0;
            end
            send(s, d);
            chk("rnd_dout", at_dout, mdout);
            chk("rnd_dvalid", at_dvalid, int'(mv));
            chk("rnd_overrun", at_ovr, int'(mo));
            chk("rnd_cnt", at_cnt, k);
            if (d) mv = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
